// File: rtl/clk_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : clk_rst_sequencer
// Brief    : MMCM reset/lock supervisor that gates the downstream system reset.
// Revision : 1.0 - initial release
// ============================================================================
module clk_rst_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 8
) (
    input  logic       clk100,
    input  logic       rst_n,
    input  logic       mmcm_locked,
    input  logic       force_relock,
    output logic       mmcm_rst,
    output logic       sys_rst_n,
    output logic       clocks_ok,
    output logic       fault,
    output logic [2:0] state_o,
    output logic [7:0] lock_loss_cnt
);

    localparam int c_CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_CNT_MAX   = (c_CNT_MAX_A > STABLE_CYCLES) ? c_CNT_MAX_A : STABLE_CYCLES;
    localparam int c_CNT_W     = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_RET_W     = $clog2(MAX_RETRIES + 1);

    localparam logic [c_CNT_W-1:0] c_RST_LAST    = c_CNT_W'(RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_LOCK_LAST   = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_LAST = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_RET_W-1:0] c_RET_MAX     = c_RET_W'(MAX_RETRIES);
    localparam logic [c_RET_W-1:0] c_RET_ONE     = c_RET_W'(1);

    localparam logic [2:0] c_ST_RESET_HOLD = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK  = 3'd1;
    localparam logic [2:0] c_ST_STABLE     = 3'd2;
    localparam logic [2:0] c_ST_RUN        = 3'd3;
    localparam logic [2:0] c_ST_FAULT      = 3'd4;

    logic               r_sync1;
    logic               r_locked_s;
    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_RET_W-1:0] r_retries;
    logic               r_mmcm_rst;
    logic               r_sys_rst_n;
    logic               r_clocks_ok;
    logic               r_fault;
    logic [7:0]         r_lock_loss_cnt;

    logic [2:0]         w_next_state;
    logic [c_CNT_W-1:0] w_next_cnt;
    logic [c_RET_W-1:0] w_next_ret;
    logic [c_RET_W-1:0] w_ret_inc;
    logic               w_lol_inc;
    logic               w_counting;

    assign w_ret_inc = r_retries + c_RET_ONE;

    always_comb begin
        w_next_state = r_state;
        w_next_ret   = r_retries;
        w_lol_inc    = 1'b0;
        w_next_cnt   = r_cnt;
        w_counting   = 1'b0;
        case (r_state)
            c_ST_RESET_HOLD: begin
                w_counting = 1'b1;
                if (r_cnt == c_RST_LAST) begin
                    w_next_state = c_ST_WAIT_LOCK;
                end
            end
            c_ST_WAIT_LOCK: begin
                w_counting = 1'b1;
                // Lock takes priority over a coincident timeout.
                if (r_locked_s) begin
                    w_next_state = c_ST_STABLE;
                end else if (r_cnt == c_LOCK_LAST) begin
                    w_next_ret   = w_ret_inc;
                    w_next_state = (w_ret_inc == c_RET_MAX) ? c_ST_FAULT : c_ST_RESET_HOLD;
                end
            end
            c_ST_STABLE: begin
                w_counting = 1'b1;
                if (!r_locked_s) begin
                    w_next_state = c_ST_RESET_HOLD;
                end else if (r_cnt == c_STABLE_LAST) begin
                    w_next_state = c_ST_RUN;
                    w_next_ret   = '0;
                end
            end
            c_ST_RUN: begin
                if (!r_locked_s) begin
                    w_next_state = c_ST_RESET_HOLD;
                    w_lol_inc    = 1'b1;
                end
            end
            c_ST_FAULT: begin
                w_next_state = c_ST_FAULT;
            end
            default: begin
                w_next_state = c_ST_RESET_HOLD;
            end
        endcase

        // Software relock overrides everything except the lock-loss tally.
        if (force_relock) begin
            w_next_state = c_ST_RESET_HOLD;
            w_next_ret   = '0;
        end

        if (force_relock || (w_next_state != r_state)) begin
            w_next_cnt = '0;
        end else if (w_counting) begin
            w_next_cnt = r_cnt + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1         <= 1'b0;
            r_locked_s      <= 1'b0;
            r_state         <= c_ST_RESET_HOLD;
            r_cnt           <= '0;
            r_retries       <= '0;
            r_mmcm_rst      <= 1'b1;
            r_sys_rst_n     <= 1'b0;
            r_clocks_ok     <= 1'b0;
            r_fault         <= 1'b0;
            r_lock_loss_cnt <= 8'd0;
        end else begin
            r_sync1     <= mmcm_locked;
            r_locked_s  <= r_sync1;
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_retries   <= w_next_ret;
            r_mmcm_rst  <= (w_next_state == c_ST_RESET_HOLD) || (w_next_state == c_ST_FAULT);
            r_sys_rst_n <= (w_next_state == c_ST_RUN);
            r_clocks_ok <= (w_next_state == c_ST_RUN);
            r_fault     <= (w_next_state == c_ST_FAULT);
            if (w_lol_inc && (r_lock_loss_cnt != 8'hFF)) begin
                r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
            end
        end
    end

    assign mmcm_rst      = r_mmcm_rst;
    assign sys_rst_n     = r_sys_rst_n;
    assign clocks_ok     = r_clocks_ok;
    assign fault         = r_fault;
    assign state_o       = r_state;
    assign lock_loss_cnt = r_lock_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clk_rst_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_rst_sequencer
// Brief    : Vector-table and scoreboard bench for clk_rst_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_rst_sequencer;

    typedef struct {
        logic       lk;
        logic       rl;
        logic [2:0] st;
        logic [7:0] lol;
    } vec_t;

    logic       r_clk = 1'b0;
    logic       r_rst_n = 1'b0;
    logic       r_locked = 1'b0;
    logic       r_relock = 1'b0;
    logic       w_mmcm_rst;
    logic       w_sys_rst_n;
    logic       w_clocks_ok;
    logic       w_fault;
    logic [2:0] w_state;
    logic [7:0] w_lol;

    int         n_checks = 0;
    int         n_errors = 0;
    vec_t       vecs[$];
    logic [15:0] sb[$];

    clk_rst_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES  (3)
    ) u_dut (
        .clk100       (r_clk),
        .rst_n        (r_rst_n),
        .mmcm_locked  (r_locked),
        .force_relock (r_relock),
        .mmcm_rst     (w_mmcm_rst),
        .sys_rst_n    (w_sys_rst_n),
        .clocks_ok    (w_clocks_ok),
        .fault        (w_fault),
        .state_o      (w_state),
        .lock_loss_cnt(w_lol)
    );

    always #5 r_clk = ~r_clk;

    function automatic logic [15:0] decode(input logic [2:0] st, input logic [7:0] lol);
        logic mr;
        logic run;
        mr  = (st == 3'd0) || (st == 3'd4);
        run = (st == 3'd3);
        return {1'b0, mr, run, run, (st == 3'd4), st, lol};
    endfunction

    function automatic logic [15:0] dut_outs();
        return {1'b0, w_mmcm_rst, w_sys_rst_n, w_clocks_ok, w_fault, w_state, w_lol};
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    task automatic add(input int n, input logic lk, input logic rl, input logic [2:0] st, input logic [7:0] lol);
        vec_t v;
        v.lk = lk; v.rl = rl; v.st = st; v.lol = lol;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    task automatic wait_state(input logic [2:0] st, input int max_cyc, input int idx);
        int n;
        n = 0;
        while ((w_state !== st) && (n < max_cyc)) begin
            @(posedge r_clk);
            #1;
            n++;
        end
        check("wait_state", idx, {13'd0, w_state}, {13'd0, st});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-up, lock arrives three cycles after mmcm_rst drops
        add(3, 0, 0, 3'd0, 8'd0);
        add(3, 0, 0, 3'd1, 8'd0);
        add(2, 1, 0, 3'd1, 8'd0);
        add(8, 1, 0, 3'd2, 8'd0);
        add(4, 1, 0, 3'd3, 8'd0);
        // One-cycle lock drop in RUN
        add(1, 0, 0, 3'd3, 8'd0);
        add(1, 1, 0, 3'd3, 8'd0);
        add(4, 1, 0, 3'd0, 8'd1);
        add(1, 1, 0, 3'd1, 8'd1);
        add(8, 1, 0, 3'd2, 8'd1);
        add(3, 1, 0, 3'd3, 8'd1);
        // Relock in RUN while locked, then coincident with synced lock loss
        add(1, 1, 1, 3'd0, 8'd1);
        add(3, 1, 0, 3'd0, 8'd1);
        add(1, 1, 0, 3'd1, 8'd1);
        add(8, 1, 0, 3'd2, 8'd1);
        add(2, 1, 0, 3'd3, 8'd1);
        add(2, 0, 0, 3'd3, 8'd1);
        add(1, 1, 1, 3'd0, 8'd2);
        add(3, 1, 0, 3'd0, 8'd2);
        add(1, 1, 0, 3'd1, 8'd2);
        add(8, 1, 0, 3'd2, 8'd2);
        add(2, 1, 0, 3'd3, 8'd2);
        // Three timeouts into FAULT, dwell, release by relock
        add(1, 0, 1, 3'd0, 8'd2);
        add(3, 0, 0, 3'd0, 8'd2);
        add(20, 0, 0, 3'd1, 8'd2);
        add(4, 0, 0, 3'd0, 8'd2);
        add(20, 0, 0, 3'd1, 8'd2);
        add(4, 0, 0, 3'd0, 8'd2);
        add(20, 0, 0, 3'd1, 8'd2);
        add(100, 0, 0, 3'd4, 8'd2);
        add(1, 0, 1, 3'd0, 8'd2);
        // Two timeouts, lock loss in STABLE at cnt=5 keeps retries, third timeout faults
        add(3, 0, 0, 3'd0, 8'd2);
        add(20, 0, 0, 3'd1, 8'd2);
        add(4, 0, 0, 3'd0, 8'd2);
        add(20, 0, 0, 3'd1, 8'd2);
        add(4, 0, 0, 3'd0, 8'd2);
        add(2, 1, 0, 3'd1, 8'd2);
        add(4, 1, 0, 3'd2, 8'd2);
        add(1, 0, 0, 3'd2, 8'd2);
        add(1, 1, 0, 3'd2, 8'd2);
        add(4, 0, 0, 3'd0, 8'd2);
        add(20, 0, 0, 3'd1, 8'd2);
        add(3, 0, 0, 3'd4, 8'd2);

        repeat (3) @(posedge r_clk);
        #1;
        check("reset_state", 0, dut_outs(), decode(3'd0, 8'd0));
        r_rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            r_locked = vecs[i].lk;
            r_relock = vecs[i].rl;
            sb.push_back(decode(vecs[i].st, vecs[i].lol));
            @(posedge r_clk);
            #1;
            check("vec", i, dut_outs(), sb.pop_front());
        end
        r_relock = 1'b0;

        // Asynchronous reset in the middle of WAIT_LOCK
        r_locked = 1'b0;
        r_relock = 1'b1;
        @(posedge r_clk);
        #1;
        r_relock = 1'b0;
        wait_state(3'd1, 20, 0);
        repeat (3) @(posedge r_clk);
        #2;
        r_rst_n = 1'b0;
        #1;
        check("async_rst_wait", 0, dut_outs(), decode(3'd0, 8'd0));

        // Asynchronous reset in the middle of RUN
        r_locked = 1'b1;
        @(negedge r_clk);
        r_rst_n = 1'b1;
        wait_state(3'd3, 60, 1);
        check("run_sys_rst_n", 0, {15'd0, w_sys_rst_n}, 16'd1);
        #2;
        r_rst_n = 1'b0;
        #1;
        check("async_rst_run", 0, dut_outs(), decode(3'd0, 8'd0));

        // 256 lock losses saturate the counter
        @(negedge r_clk);
        r_rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wait_state(3'd3, 60, 100 + i);
            r_locked = 1'b0;
            @(posedge r_clk);
            #1;
            r_locked = 1'b1;
            repeat (2) @(posedge r_clk);
            #1;
            if (i == 0)   check("lol_first", i, {8'd0, w_lol}, 16'd1);
            if (i == 254) check("lol_255", i, {8'd0, w_lol}, 16'd255);
        end
        check("lol_sat", 0, {8'd0, w_lol}, 16'd255);
        check("lol_sat_state", 0, {13'd0, w_state}, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
